// File: rtl/sign_ext_arbiter_pkg.sv
// Shared definitions for the sign/zero-extension arbiter and the decode stage.
package sign_ext_arbiter_pkg;

  localparam int DEF_IN_WIDTH  = 3;
  localparam int DEF_OUT_WIDTH = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sign_ext_arbiter_core.sv
// Combinational sign/zero extension of one IN_WIDTH field to OUT_WIDTH bits.
module sign_ext_core
  import sign_ext_arbiter_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic [IN_WIDTH-1:0]  in_field,
  input  logic                 zext,
  output logic [OUT_WIDTH-1:0] out_field
);

  logic fill;

  always_comb begin
    fill      = zext ? 1'b0 : in_field[IN_WIDTH-1];
    out_field = {{(OUT_WIDTH-IN_WIDTH){fill}}, in_field};
  end

endmodule

// File: rtl/sign_ext_arbiter.sv
// Round-robin arbiter sharing one extension datapath, with a single-entry
// valid/ready output register tagged with the winning requester's ID.
module sign_ext_arbiter
  import sign_ext_arbiter_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int IN_WIDTH  = DEF_IN_WIDTH,
  parameter  int OUT_WIDTH = DEF_OUT_WIDTH,
  localparam int ID_W      = clog2(NUM_REQ)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*IN_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]           req_zext,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         out_valid,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic [ID_W-1:0]              out_id,
  input  logic                         out_ready
);

  state_e                state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       winner;
  logic [ID_W-1:0]       idx;
  logic                  found;
  logic                  can_accept;
  logic                  take;
  logic [IN_WIDTH-1:0]   sel_field;
  logic                  sel_zext;
  logic [OUT_WIDTH-1:0]  ext_field;

  // Search from rr_ptr upward with explicit modulo so non-power-of-two
  // NUM_REQ wraps from NUM_REQ-1 back to 0.
  always_comb begin
    winner    = '0;
    idx       = '0;
    found     = 1'b0;
    sel_field = '0;
    sel_zext  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found     = 1'b1;
        winner    = idx;
        sel_field = req_data[idx*IN_WIDTH +: IN_WIDTH];
        sel_zext  = req_zext[idx];
      end
    end
    can_accept = (state == ST_EMPTY) || (out_valid && out_ready);
    take       = found && can_accept && !reset;
    gnt        = '0;
    if (take) gnt[winner] = 1'b1;
  end

  sign_ext_core #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_core (
    .in_field  (sel_field),
    .zext      (sel_zext),
    .out_field (ext_field)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      rr_ptr    <= '0;
    end else if (take) begin
      state     <= ST_FULL;
      out_valid <= 1'b1;
      out_data  <= ext_field;
      out_id    <= winner;
      rr_ptr    <= (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
    end else if (out_valid && out_ready) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sign_ext_arbiter.sv
// Randomized and directed checks of sign_ext_arbiter (4x3->8 and 3x4->8).
module tb_sign_ext_arbiter;

  logic        clock;
  logic        reset;

  logic [3:0]  a_req, a_zext, a_gnt;
  logic [11:0] a_data;
  logic        a_valid, a_ready;
  logic [7:0]  a_dout;
  logic [1:0]  a_id;

  logic [2:0]  b_req, b_zext, b_gnt;
  logic [11:0] b_data;
  logic        b_valid, b_ready;
  logic [7:0]  b_dout;
  logic [1:0]  b_id;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit          ma_valid, mb_valid;
  logic [7:0]  ma_data, mb_data;
  int          ma_id, ma_ptr, mb_id, mb_ptr;
  int          wa, wb;
  logic [3:0]  a_gnt_seen;
  logic [2:0]  b_gnt_seen;

  sign_ext_arbiter #(.NUM_REQ(4), .IN_WIDTH(3), .OUT_WIDTH(8)) dut_a (
    .clock(clock), .reset(reset), .req(a_req), .req_data(a_data),
    .req_zext(a_zext), .gnt(a_gnt), .out_valid(a_valid), .out_data(a_dout),
    .out_id(a_id), .out_ready(a_ready)
  );

  sign_ext_arbiter #(.NUM_REQ(3), .IN_WIDTH(4), .OUT_WIDTH(8)) dut_b (
    .clock(clock), .reset(reset), .req(b_req), .req_data(b_data),
    .req_zext(b_zext), .gnt(b_gnt), .out_valid(b_valid), .out_data(b_dout),
    .out_id(b_id), .out_ready(b_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int ptr, input int n);
    for (int k = 0; k < n; k++) begin
      int i;
      i = (ptr + k) % n;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // Extension as arithmetic: sign mode treats the field as two's complement.
  function automatic logic [7:0] ref_ext(input int x, input int iw, input bit z);
    int v;
    v = x;
    if (!z && x >= (1 << (iw - 1))) v = x - (1 << iw);
    return 8'(v);
  endfunction

  task automatic tick();
    @(negedge clock);
    wa = reset ? -1 : ((!ma_valid || a_ready) ? pick(8'(a_req), ma_ptr, 4) : -1);
    wb = reset ? -1 : ((!mb_valid || b_ready) ? pick(8'(b_req), mb_ptr, 3) : -1);
    a_gnt_seen = a_gnt;
    b_gnt_seen = b_gnt;
    check("a_gnt",   32'(a_gnt),   wa >= 0 ? 32'd1 << wa : 32'd0);
    check("a_valid", 32'(a_valid), 32'(ma_valid));
    check("a_data",  32'(a_dout),  32'(ma_data));
    check("a_id",    32'(a_id),    32'(ma_id));
    check("b_gnt",   32'(b_gnt),   wb >= 0 ? 32'd1 << wb : 32'd0);
    check("b_valid", 32'(b_valid), 32'(mb_valid));
    check("b_data",  32'(b_dout),  32'(mb_data));
    check("b_id",    32'(b_id),    32'(mb_id));
    @(posedge clock);
    if (reset) begin
      ma_valid = 0; ma_data = '0; ma_id = 0; ma_ptr = 0;
      mb_valid = 0; mb_data = '0; mb_id = 0; mb_ptr = 0;
    end else begin
      if (wa >= 0) begin
        ma_data  = ref_ext(int'(a_data >> (wa * 3)) & 7, 3, a_zext[wa]);
        ma_id    = wa;
        ma_valid = 1;
        ma_ptr   = (wa + 1) % 4;
      end else if (ma_valid && a_ready) ma_valid = 0;
      if (wb >= 0) begin
        mb_data  = ref_ext(int'(b_data >> (wb * 4)) & 15, 4, b_zext[wb]);
        mb_id    = wb;
        mb_valid = 1;
        mb_ptr   = (wb + 1) % 3;
      end else if (mb_valid && b_ready) mb_valid = 0;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_req = '0; a_data = '0; a_zext = '0; a_ready = 1'b1;
    b_req = '0; b_data = '0; b_zext = '0; b_ready = 1'b1;
    ma_valid = 0; ma_data = '0; ma_id = 0; ma_ptr = 0;
    mb_valid = 0; mb_data = '0; mb_id = 0; mb_ptr = 0;
    @(posedge clock); #1;

    // second reset cycle with a request present: gnt must stay low
    a_req = 4'b0001;
    tick();
    check("rst_gnt_forced", 32'(a_gnt_seen), 32'd0);
    check("rst_valid", 32'(a_valid), 32'd0);
    reset = 1'b0;

    a_data = 12'h003; a_zext = '0;
    tick();
    check("t1_gnt", 32'(a_gnt_seen), 32'b0001);
    a_req = '0;
    check("t1_valid", 32'(a_valid), 32'd1);
    check("t1_data",  32'(a_dout),  32'h03);
    check("t1_id",    32'(a_id),    32'd0);

    a_req = 4'b0100; a_data = 12'(5 << 6); a_zext = 4'b0000;
    tick();
    check("sext_data", 32'(a_dout), 32'hFD);
    check("sext_id",   32'(a_id),   32'd2);
    a_zext = 4'b0100;
    tick();
    a_req = '0;
    check("zext_data", 32'(a_dout), 32'h05);
    check("zext_id",   32'(a_id),   32'd2);

    reset = 1'b1; tick(); reset = 1'b0;
    a_zext = '0;
    a_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_gnt", 32'(a_gnt_seen), 32'd1 << (k % 4));
      check("rr_id",  32'(a_id),       32'(k % 4));
    end

    a_ready = 1'b0; a_req = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_gnt",   32'(a_gnt_seen), 32'd0);
      check("bp_id",    32'(a_id),       32'd0);
      check("bp_valid", 32'(a_valid),    32'd1);
    end
    a_ready = 1'b1;
    tick();
    check("bp_pop_gnt", 32'(a_gnt_seen), 32'b0010);
    check("bp_pop_id",  32'(a_id),       32'd1);
    a_req = 4'b0100;

    a_ready = 1'b0;
    tick();
    reset = 1'b1; a_req = 4'b1000;
    tick();
    check("mid_rst_gnt",   32'(a_gnt_seen), 32'd0);
    check("mid_rst_valid", 32'(a_valid),    32'd0);
    reset = 1'b0; a_ready = 1'b1;
    tick();
    a_req = '0;
    check("post_rst_id",    32'(a_id),    32'd3);
    check("post_rst_valid", 32'(a_valid), 32'd1);

    b_req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("b_rr_id", 32'(b_id), 32'(k % 3));
    end
    b_req = 3'b010; b_data = 12'(8 << 4); b_zext = '0;
    tick();
    b_req = '0;
    check("b_sext_data", 32'(b_dout), 32'hF8);
    check("b_sext_id",   32'(b_id),   32'd1);

    for (int n = 0; n < 400; n++) begin
      reset   = ($urandom_range(0, 49) == 0);
      a_req   = a_req | (4'($urandom) & 4'($urandom));
      a_data  = 12'($urandom);
      a_zext  = 4'($urandom);
      a_ready = ($urandom_range(0, 3) != 0);
      b_req   = b_req | (3'($urandom) & 3'($urandom));
      b_data  = 12'($urandom);
      b_zext  = 3'($urandom);
      b_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (wa >= 0) a_req = a_req & ~4'(1 << wa);
      if (wb >= 0) b_req = b_req & ~3'(1 << wb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
